// File: rtl/mac_dispatcher.sv
// Binds each input job to a free MAC lane round-robin and returns lane results in dispatch order.
// One bubble cycle per job dispatch, then zero-latency beat pass-through; lane TREADY backpressures the job stream.

module mac_dispatcher_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign do_rd  = rd_rdy && rd_vld;

  // Writer never pushes when full; the caller guarantees that.
  always_ff @(posedge ACLK) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd)  rd_ptr <= ptr_inc(rd_ptr);
      if (wr_vld && !do_rd)      count <= count + 1'b1;
      else if (!wr_vld && do_rd) count <= count - 1'b1;
    end
  end
endmodule

module mac_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MACS   = 4,
  parameter int LW         = $clog2(NUM_MACS)
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       SD_AXIS_TVALID,
  output logic                       SD_AXIS_TREADY,
  input  logic [2*DATA_WIDTH-1:0]    SD_AXIS_TDATA,
  input  logic                       SD_AXIS_TLAST,
  input  logic                       SD_AXIS_TUSER,
  input  logic [7:0]                 SD_AXIS_TID,
  output logic [NUM_MACS-1:0]        MD_AXIS_TVALID,
  input  logic [NUM_MACS-1:0]        MD_AXIS_TREADY,
  output logic [2*DATA_WIDTH-1:0]    MD_AXIS_TDATA,
  output logic                       MD_AXIS_TLAST,
  output logic                       MD_AXIS_TUSER,
  output logic [7:0]                 MD_AXIS_TID,
  input  logic [NUM_MACS-1:0]        SR_AXIS_TVALID,
  output logic [NUM_MACS-1:0]        SR_AXIS_TREADY,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] SR_AXIS_TDATA,
  input  logic [NUM_MACS-1:0]        SR_AXIS_TLAST,
  input  logic [NUM_MACS*8-1:0]      SR_AXIS_TID,
  output logic                       MO_AXIS_TVALID,
  input  logic                       MO_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]      MO_AXIS_TDATA,
  output logic                       MO_AXIS_TLAST,
  output logic [7:0]                 MO_AXIS_TID,
  output logic [LW:0]                OUTSTANDING
);
  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] cur_lane;
  logic [LW-1:0] rr_ptr;
  logic [NUM_MACS-1:0] busy;
  logic          push;
  logic          pop;
  logic          job_done;
  logic          free_found;
  logic [LW-1:0] free_lane;
  logic [LW:0]   cand_sum;
  logic [LW-1:0] cand;
  logic          fifo_vld;
  logic [LW-1:0] head;
  logic [LW-1:0] lane_inc;

  assign MD_AXIS_TDATA = SD_AXIS_TDATA;
  assign MD_AXIS_TLAST = SD_AXIS_TLAST;
  assign MD_AXIS_TUSER = SD_AXIS_TUSER;
  assign MD_AXIS_TID   = SD_AXIS_TID;

  // Descending scan so the lane closest above rr_ptr is the last one written.
  always_comb begin
    free_found = 1'b0;
    free_lane  = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = NUM_MACS - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + (LW+1)'(k);
      if (cand_sum >= (LW+1)'(NUM_MACS)) cand_sum = cand_sum - (LW+1)'(NUM_MACS);
      cand = cand_sum[LW-1:0];
      if (!busy[cand]) begin
        free_found = 1'b1;
        free_lane  = cand;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    SD_AXIS_TREADY = 1'b0;
    MD_AXIS_TVALID = '0;
    push           = 1'b0;
    job_done       = 1'b0;
    case (state)
      IDLE: begin
        if (SD_AXIS_TVALID && free_found) begin
          push      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        MD_AXIS_TVALID[cur_lane] = SD_AXIS_TVALID;
        SD_AXIS_TREADY           = MD_AXIS_TREADY[cur_lane];
        if (SD_AXIS_TVALID && MD_AXIS_TREADY[cur_lane] && SD_AXIS_TLAST) begin
          job_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lane_inc = (cur_lane == LW'(NUM_MACS - 1)) ? '0 : cur_lane + 1'b1;

  // The popping lane is still busy this cycle, so it can never collide with free_lane.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cur_lane <= '0;
      rr_ptr   <= '0;
      busy     <= '0;
    end else begin
      if (push)     cur_lane <= free_lane;
      if (job_done) rr_ptr   <= lane_inc;
      if (pop)      busy[head] <= 1'b0;
      if (push)     busy[free_lane] <= 1'b1;
    end
  end

  mac_dispatcher_fifo #(
    .W     (LW),
    .DEPTH (NUM_MACS),
    .CW    (LW + 1)
  ) u_order_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_vld  (push),
    .wr_dat  (free_lane),
    .rd_rdy  (pop),
    .rd_vld  (fifo_vld),
    .rd_dat  (head),
    .count   (OUTSTANDING)
  );

  assign MO_AXIS_TVALID = fifo_vld && SR_AXIS_TVALID[head];
  assign MO_AXIS_TDATA  = SR_AXIS_TDATA[int'(head) * DATA_WIDTH +: DATA_WIDTH];
  assign MO_AXIS_TLAST  = SR_AXIS_TLAST[head];
  assign MO_AXIS_TID    = SR_AXIS_TID[int'(head) * 8 +: 8];
  assign pop            = MO_AXIS_TVALID && MO_AXIS_TREADY;

  always_comb begin
    SR_AXIS_TREADY = '0;
    if (fifo_vld) SR_AXIS_TREADY[head] = MO_AXIS_TREADY;
  end
endmodule

// File: tb/tb_mac_dispatcher.sv
// Scoreboard bench for mac_dispatcher: lane beats and merged results checked against queues filled at stimulus time.
module tb_mac_dispatcher;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int LW = 2;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic              SD_AXIS_TVALID, SD_AXIS_TREADY, SD_AXIS_TLAST, SD_AXIS_TUSER;
  logic [2*DW-1:0]   SD_AXIS_TDATA;
  logic [7:0]        SD_AXIS_TID;
  logic [N-1:0]      MD_AXIS_TVALID, MD_AXIS_TREADY;
  logic [2*DW-1:0]   MD_AXIS_TDATA;
  logic              MD_AXIS_TLAST, MD_AXIS_TUSER;
  logic [7:0]        MD_AXIS_TID;
  logic [N-1:0]      SR_AXIS_TVALID, SR_AXIS_TREADY, SR_AXIS_TLAST;
  logic [N*DW-1:0]   SR_AXIS_TDATA;
  logic [N*8-1:0]    SR_AXIS_TID;
  logic              MO_AXIS_TVALID, MO_AXIS_TREADY, MO_AXIS_TLAST;
  logic [DW-1:0]     MO_AXIS_TDATA;
  logic [7:0]        MO_AXIS_TID;
  logic [LW:0]       OUTSTANDING;

  mac_dispatcher #(.DATA_WIDTH(DW), .NUM_MACS(N), .LW(LW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .SD_AXIS_TVALID(SD_AXIS_TVALID), .SD_AXIS_TREADY(SD_AXIS_TREADY), .SD_AXIS_TDATA(SD_AXIS_TDATA),
    .SD_AXIS_TLAST(SD_AXIS_TLAST), .SD_AXIS_TUSER(SD_AXIS_TUSER), .SD_AXIS_TID(SD_AXIS_TID),
    .MD_AXIS_TVALID(MD_AXIS_TVALID), .MD_AXIS_TREADY(MD_AXIS_TREADY), .MD_AXIS_TDATA(MD_AXIS_TDATA),
    .MD_AXIS_TLAST(MD_AXIS_TLAST), .MD_AXIS_TUSER(MD_AXIS_TUSER), .MD_AXIS_TID(MD_AXIS_TID),
    .SR_AXIS_TVALID(SR_AXIS_TVALID), .SR_AXIS_TREADY(SR_AXIS_TREADY), .SR_AXIS_TDATA(SR_AXIS_TDATA),
    .SR_AXIS_TLAST(SR_AXIS_TLAST), .SR_AXIS_TID(SR_AXIS_TID),
    .MO_AXIS_TVALID(MO_AXIS_TVALID), .MO_AXIS_TREADY(MO_AXIS_TREADY), .MO_AXIS_TDATA(MO_AXIS_TDATA),
    .MO_AXIS_TLAST(MO_AXIS_TLAST), .MO_AXIS_TID(MO_AXIS_TID),
    .OUTSTANDING(OUTSTANDING)
  );

  typedef struct packed {
    logic [LW-1:0]   lane;
    logic [2*DW-1:0] data;
    logic            last;
    logic            user;
    logic [7:0]      tid;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    tid;
  } res_t;

  beat_t exp_md[$];
  res_t  exp_mo[$];
  beat_t mon_b;
  res_t  mon_r;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] res_of(input int tid);
    return 32'hA500_1200 | 32'(tid);
  endfunction

  always @(negedge ACLK) begin
    if (ARESETN) begin
      chk("md_onehot", 64'($countones(MD_AXIS_TVALID) <= 1), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (MD_AXIS_TVALID[i] && MD_AXIS_TREADY[i]) begin
          if (exp_md.size() == 0) chk("md_extra_beat", 64'(exp_md.size()), 64'd1);
          else begin
            mon_b = exp_md.pop_front();
            chk("md_lane", 64'(i), 64'(mon_b.lane));
            chk("md_data", 64'(MD_AXIS_TDATA), 64'(mon_b.data));
            chk("md_last", 64'(MD_AXIS_TLAST), 64'(mon_b.last));
            chk("md_user", 64'(MD_AXIS_TUSER), 64'(mon_b.user));
            chk("md_tid",  64'(MD_AXIS_TID),   64'(mon_b.tid));
          end
        end
      end
      if (MO_AXIS_TVALID && MO_AXIS_TREADY) begin
        if (exp_mo.size() == 0) chk("mo_extra_result", 64'(exp_mo.size()), 64'd1);
        else begin
          mon_r = exp_mo.pop_front();
          chk("mo_data", 64'(MO_AXIS_TDATA), 64'(mon_r.data));
          chk("mo_tid",  64'(MO_AXIS_TID),   64'(mon_r.tid));
          chk("mo_last", 64'(MO_AXIS_TLAST), 64'd1);
        end
      end
    end
  end

  task automatic present(input int tid, input int k, input int n, input int lane);
    beat_t b;
    SD_AXIS_TVALID = 1'b1;
    SD_AXIS_TDATA  = {8'(tid), 8'(k), 16'hBEEF, 32'h1000_0000 + 32'(k)};
    SD_AXIS_TLAST  = (k == n - 1);
    SD_AXIS_TUSER  = k[0];
    SD_AXIS_TID    = 8'(tid);
    b.lane = LW'(lane);
    b.data = SD_AXIS_TDATA;
    b.last = SD_AXIS_TLAST;
    b.user = SD_AXIS_TUSER;
    b.tid  = SD_AXIS_TID;
    exp_md.push_back(b);
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge ACLK);
    while (!SD_AXIS_TREADY && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!SD_AXIS_TREADY) chk("sd_accept_timeout", 64'(SD_AXIS_TREADY), 64'd1);
    @(posedge ACLK); #1;
    SD_AXIS_TVALID = 1'b0;
  endtask

  task automatic send_job(input int tid, input int n, input int lane, input logic [DW-1:0] rdat,
                          input int stall_k = -1);
    res_t r;
    r.data = rdat;
    r.tid  = 8'(tid);
    exp_mo.push_back(r);
    for (int k = 0; k < n; k++) begin
      present(tid, k, n, lane);
      if (k == stall_k) begin
        MD_AXIS_TREADY[lane] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge ACLK);
          chk("bp_sd_rdy_low", 64'(SD_AXIS_TREADY), 64'd0);
          chk("bp_md_vld_held", 64'(MD_AXIS_TVALID[lane]), 64'd1);
        end
        @(posedge ACLK); #1;
        MD_AXIS_TREADY[lane] = 1'b1;
      end
      wait_accept();
    end
  endtask

  task automatic set_res(input int lane, input logic [DW-1:0] data, input int tid);
    SR_AXIS_TVALID[lane]          = 1'b1;
    SR_AXIS_TDATA[lane*DW +: DW]  = data;
    SR_AXIS_TID[lane*8 +: 8]      = 8'(tid);
  endtask

  // Clears each lane's result valid right after its handshake edge.
  task automatic drain(input int n);
    int got = 0;
    int t = 0;
    int hs;
    while (got < n && t < 300) begin
      @(negedge ACLK);
      hs = -1;
      for (int i = 0; i < N; i++) if (SR_AXIS_TVALID[i] && SR_AXIS_TREADY[i]) hs = i;
      @(posedge ACLK); #1;
      if (hs >= 0) begin
        SR_AXIS_TVALID[hs] = 1'b0;
        got++;
      end
      t++;
    end
    if (got < n) chk("drain_timeout", 64'(got), 64'(n));
  endtask

  task automatic check_drained();
    chk("md_queue_empty", 64'(exp_md.size()), 64'd0);
    chk("mo_queue_empty", 64'(exp_mo.size()), 64'd0);
  endtask

  task automatic do_reset();
    SD_AXIS_TVALID = 1'b0;
    SR_AXIS_TVALID = '0;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
  endtask

  task automatic post_reset_idle(input string tag);
    chk({tag, "_sd_rdy"}, 64'(SD_AXIS_TREADY), 64'd0);
    chk({tag, "_md_vld"}, 64'(MD_AXIS_TVALID), 64'd0);
    chk({tag, "_sr_rdy"}, 64'(SR_AXIS_TREADY), 64'd0);
    chk({tag, "_mo_vld"}, 64'(MO_AXIS_TVALID), 64'd0);
    chk({tag, "_outst"},  64'(OUTSTANDING),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    SD_AXIS_TVALID = 1'b0; SD_AXIS_TDATA = '0; SD_AXIS_TLAST = 1'b0; SD_AXIS_TUSER = 1'b0; SD_AXIS_TID = '0;
    MD_AXIS_TREADY = '1; MO_AXIS_TREADY = 1'b1;
    SR_AXIS_TVALID = '1; SR_AXIS_TDATA = '0; SR_AXIS_TLAST = '1; SR_AXIS_TID = '0;

    // Reset with every lane result asserted: nothing may leak out of an empty order FIFO.
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    post_reset_idle("reset");
    @(posedge ACLK); #1;
    SR_AXIS_TVALID = '0;

    // Single 3-beat job, TID 5, lane 0, one dispatch bubble.
    begin
      res_t r;
      r.data = 32'h1234; r.tid = 8'd5;
      exp_mo.push_back(r);
    end
    present(5, 0, 3, 0);
    @(negedge ACLK);
    chk("bubble_sd_rdy", 64'(SD_AXIS_TREADY), 64'd0);
    chk("bubble_md_vld", 64'(MD_AXIS_TVALID), 64'd0);
    chk("bubble_outst",  64'(OUTSTANDING),    64'd0);
    @(negedge ACLK);
    chk("job1_sd_rdy", 64'(SD_AXIS_TREADY), 64'd1);
    chk("job1_lane0",  64'(MD_AXIS_TVALID), 64'b0001);
    chk("job1_outst",  64'(OUTSTANDING),    64'd1);
    @(posedge ACLK); #1;
    present(5, 1, 3, 0); wait_accept();
    present(5, 2, 3, 0); wait_accept();
    @(negedge ACLK);
    chk("job1_idle_md", 64'(MD_AXIS_TVALID), 64'd0);
    chk("job1_outst_held", 64'(OUTSTANDING), 64'd1);
    @(posedge ACLK); #1;
    set_res(0, 32'h1234, 5);
    drain(1);
    @(negedge ACLK);
    chk("job1_outst_back0", 64'(OUTSTANDING), 64'd0);
    @(posedge ACLK); #1;

    // Round robin across all lanes, then a fifth job stalls until lane 0 returns.
    check_drained();
    do_reset();
    for (int j = 0; j < 4; j++) send_job(10 + j, 2, j, res_of(10 + j));
    begin
      res_t r;
      r.data = res_of(14); r.tid = 8'd14;
      exp_mo.push_back(r);
    end
    present(14, 0, 2, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk("full_sd_rdy", 64'(SD_AXIS_TREADY), 64'd0);
      chk("full_outst",  64'(OUTSTANDING),    64'd4);
    end
    @(posedge ACLK); #1;
    set_res(0, res_of(10), 10);
    drain(1);
    wait_accept();
    present(14, 1, 2, 0); wait_accept();
    set_res(1, res_of(11), 11);
    set_res(2, res_of(12), 12);
    set_res(3, res_of(13), 13);
    set_res(0, res_of(14), 14);
    drain(4);

    // Reorder: lanes 2 and 1 finish before lane 0.
    check_drained();
    do_reset();
    for (int j = 0; j < 3; j++) send_job(20 + j, 2, j, res_of(20 + j));
    set_res(2, res_of(22), 22);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk("reorder_mo_hold", 64'(MO_AXIS_TVALID),    64'd0);
      chk("reorder_sr2_rdy", 64'(SR_AXIS_TREADY[2]), 64'd0);
    end
    @(posedge ACLK); #1;
    set_res(1, res_of(21), 21);
    @(negedge ACLK);
    chk("reorder_mo_hold2", 64'(MO_AXIS_TVALID), 64'd0);
    chk("reorder_sr_head",  64'(SR_AXIS_TREADY), 64'b0001);
    @(posedge ACLK); #1;
    set_res(0, res_of(20), 20);
    drain(3);

    // Lane backpressure for 3 cycles in the middle of a 4-beat job.
    check_drained();
    do_reset();
    send_job(30, 4, 0, res_of(30), 2);
    set_res(0, res_of(30), 30);
    drain(1);

    // Pop of lane 1 on the same edge as a new dispatch.
    check_drained();
    do_reset();
    send_job(40, 2, 0, res_of(40));
    send_job(41, 2, 1, res_of(41));
    set_res(0, res_of(40), 40);
    drain(1);
    set_res(1, res_of(41), 41);
    begin
      res_t r;
      r.data = res_of(42); r.tid = 8'd42;
      exp_mo.push_back(r);
    end
    present(42, 0, 2, 2);
    @(negedge ACLK);
    chk("sim_pre_outst", 64'(OUTSTANDING), 64'd1);
    chk("sim_pop_now",   64'(MO_AXIS_TVALID && MO_AXIS_TREADY), 64'd1);
    chk("sim_idle_rdy",  64'(SD_AXIS_TREADY), 64'd0);
    @(posedge ACLK); #1;
    SR_AXIS_TVALID[1] = 1'b0;
    @(negedge ACLK);
    chk("sim_outst_same", 64'(OUTSTANDING),    64'd1);
    chk("sim_lane2",      64'(MD_AXIS_TVALID), 64'b0100);
    @(posedge ACLK); #1;
    present(42, 1, 2, 2); wait_accept();
    send_job(43, 1, 3, res_of(43));
    send_job(44, 1, 0, res_of(44));
    send_job(45, 1, 1, res_of(45));
    @(negedge ACLK);
    chk("sim_outst_full", 64'(OUTSTANDING), 64'd4);
    @(posedge ACLK); #1;
    set_res(2, res_of(42), 42);
    set_res(3, res_of(43), 43);
    set_res(0, res_of(44), 44);
    set_res(1, res_of(45), 45);
    drain(4);

    // Reset after beat 2 of a 4-beat job; the job is dropped and the next one restarts at lane 0.
    check_drained();
    do_reset();
    present(50, 0, 4, 0); wait_accept();
    present(50, 1, 4, 0); wait_accept();
    SD_AXIS_TVALID = 1'b1;
    SD_AXIS_TDATA  = 64'hDEAD_0050_0000_0002;
    SD_AXIS_TLAST  = 1'b0;
    SR_AXIS_TVALID[0] = 1'b1;
    SR_AXIS_TDATA[0 +: DW] = res_of(50);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    present(51, 0, 1, 0);
    @(negedge ACLK);
    post_reset_idle("midjob");
    SR_AXIS_TVALID[0] = 1'b0;
    begin
      res_t r;
      r.data = res_of(51); r.tid = 8'd51;
      exp_mo.push_back(r);
    end
    wait_accept();
    @(negedge ACLK);
    chk("midjob_outst", 64'(OUTSTANDING), 64'd1);
    @(posedge ACLK); #1;
    set_res(0, res_of(51), 51);
    drain(1);

    repeat (3) @(posedge ACLK);
    #1;
    check_drained();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
